// File: rtl/sid_pkg.sv
// Shared constants and types for the SID pipeline scheduler.
// No logic; pure declarations.
// Imported by the scheduler top and its filter sequencer.
package sid;
    localparam int SID_MAX       = 4;
    localparam int VOICE_LAT     = 2;
    localparam int FILTER_STAGES = 7;
    localparam int SID_IDX_W     = $clog2(SID_MAX);

    // One voice slot of the shared voice pipeline: which core, which voice.
    typedef struct packed {
        logic [SID_IDX_W-1:0] sid;
        logic [1:0]           voice;
    } sched_voice_t;
endpackage

// File: rtl/sid_filter_seq.sv
// Filter pass sequencer: pending-core mask, lowest-core pick, 7-stage counter, audio strobes.
// Latency: filt_load in the cycle a core turns ready (if idle or in last stage); audio 1 cycle after last stage.
// Backpressure: none; ready cores wait in the pending mask until the filter frees up.
module sid_filter_seq
    import sid::*;
#(
    parameter int NUM_SIDS = 2,
    parameter int SID_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mark_vld,
    input  logic [SID_W-1:0] mark_sid,
    output logic             filt_load,
    output logic [SID_W-1:0] filt_sid,
    output logic [2:0]       filt_stage,
    output logic             audio_valid,
    output logic [SID_W-1:0] audio_sid,
    output logic             frame_done
);
    localparam logic [2:0] LAST_STAGE = 3'(FILTER_STAGES);

    typedef enum logic {F_IDLE, F_RUN} fstate_t;

    fstate_t             state_q, state_n;
    logic [NUM_SIDS-1:0] pend_q, pend_n, ready;
    logic [SID_W-1:0]    pick, pass_q, pass_n, fsid_n, asid_n;
    logic [2:0]          stage_n;
    logic                any_rdy, take, load_n, aud_n, done_n;

    // Ready set includes a core whose last voice is being captured this cycle; pick lowest index.
    always_comb begin
        ready = pend_q;
        pick  = '0;
        for (int i = 0; i < NUM_SIDS; i++) begin
            if (mark_vld && mark_sid == SID_W'(i)) ready[i] = 1'b1;
        end
        for (int i = NUM_SIDS - 1; i >= 0; i--) begin
            if (ready[i]) pick = SID_W'(i);
        end
        any_rdy = |ready;
    end

    // Next-state: load when idle or entering the last stage, step stages, strobe audio after the last.
    always_comb begin
        state_n = state_q;
        stage_n = filt_stage;
        load_n  = 1'b0;
        fsid_n  = filt_sid;
        pass_n  = pass_q;
        aud_n   = 1'b0;
        asid_n  = audio_sid;
        done_n  = 1'b0;
        take    = 1'b0;
        case (state_q)
            F_IDLE: begin
                if (filt_load) begin
                    state_n = F_RUN;
                    stage_n = 3'd1;
                    pass_n  = filt_sid;
                end else if (any_rdy) begin
                    take = 1'b1;
                end
            end
            F_RUN: begin
                if (filt_stage == LAST_STAGE) begin
                    aud_n  = 1'b1;
                    asid_n = pass_q;
                    done_n = (pass_q == SID_W'(NUM_SIDS - 1));
                    if (filt_load) begin
                        stage_n = 3'd1;
                        pass_n  = filt_sid;
                    end else begin
                        state_n = F_IDLE;
                        stage_n = 3'd0;
                    end
                end else begin
                    stage_n = filt_stage + 3'd1;
                    if (filt_stage == LAST_STAGE - 3'd1 && any_rdy) take = 1'b1;
                end
            end
            default: state_n = F_IDLE;
        endcase
        if (take) begin
            load_n = 1'b1;
            fsid_n = pick;
        end
        pend_n = ready;
        for (int i = 0; i < NUM_SIDS; i++) begin
            if (take && pick == SID_W'(i)) pend_n[i] = 1'b0;
        end
    end

    // State, pending mask and registered strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= F_IDLE;
            pend_q      <= '0;
            pass_q      <= '0;
            filt_load   <= 1'b0;
            filt_sid    <= '0;
            filt_stage  <= 3'd0;
            audio_valid <= 1'b0;
            audio_sid   <= '0;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_n;
            pend_q      <= pend_n;
            pass_q      <= pass_n;
            filt_load   <= load_n;
            filt_sid    <= fsid_n;
            filt_stage  <= stage_n;
            audio_valid <= aud_n;
            audio_sid   <= asid_n;
            frame_done  <= done_n;
        end
    end
endmodule

// File: rtl/sid_pipe_sched.sv
// Frame scheduler sharing one voice pipeline and one filter pipeline among NUM_SIDS cores.
// Latency: first issue 1 cycle after start, capture 2 cycles after issue, frame 6+7*NUM_SIDS cycles.
// Backpressure: none; a start while a frame is running (and not finishing) is dropped and flagged by overrun.
module sid_pipe_sched
    import sid::*;
#(
    parameter int NUM_SIDS = 2,
    parameter int SID_W    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             vsel_valid,
    output logic [SID_W-1:0] vsel_sid,
    output logic [1:0]       vsel_voice,
    output logic             voice_active,
    output logic             cap_valid,
    output logic [SID_W-1:0] cap_sid,
    output logic [1:0]       cap_voice,
    output logic             filt_load,
    output logic [SID_W-1:0] filt_sid,
    output logic [2:0]       filt_stage,
    output logic             audio_valid,
    output logic [SID_W-1:0] audio_sid,
    output logic             frame_done,
    output logic             overrun
);
    typedef enum logic {V_IDLE, V_ISSUE} vstate_t;

    vstate_t                vstate_q, vstate_n;
    sched_voice_t           slot_q, slot_n;
    logic [VOICE_LAT-1:0]   dly_vld;
    sched_voice_t           dly_slot [VOICE_LAT];
    logic                   accept, mark_vld;

    // A new frame may begin in the same cycle the previous one delivers its last audio.
    assign accept = start && (!busy || frame_done);

    assign vsel_valid   = (vstate_q == V_ISSUE);
    assign vsel_sid     = SID_W'(slot_q.sid);
    assign vsel_voice   = slot_q.voice;
    assign voice_active = dly_vld[0];
    assign cap_valid    = dly_vld[VOICE_LAT-1];
    assign cap_sid      = SID_W'(dly_slot[VOICE_LAT-1].sid);
    assign cap_voice    = dly_slot[VOICE_LAT-1].voice;
    // Core is ready for filtering as its voice 2 capture goes out, hence one stage early.
    assign mark_vld     = dly_vld[VOICE_LAT-2] && dly_slot[VOICE_LAT-2].voice == 2'd2;

    // Voice issue sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vstate_q <= V_IDLE;
            slot_q   <= '0;
        end else begin
            vstate_q <= vstate_n;
            slot_q   <= slot_n;
        end
    end

    // Walk sid 0 voices 0..2, sid 1 voices 0..2, ... then return to idle.
    always_comb begin
        vstate_n = vstate_q;
        slot_n   = slot_q;
        case (vstate_q)
            V_IDLE: begin
                slot_n = '0;
                if (accept) vstate_n = V_ISSUE;
            end
            V_ISSUE: begin
                if (slot_q.voice == 2'd2) begin
                    slot_n.voice = 2'd0;
                    if (slot_q.sid == SID_IDX_W'(NUM_SIDS - 1)) begin
                        vstate_n   = V_IDLE;
                        slot_n.sid = '0;
                    end else begin
                        slot_n.sid = slot_q.sid + SID_IDX_W'(1);
                    end
                end else begin
                    slot_n.voice = slot_q.voice + 2'd1;
                end
            end
            default: vstate_n = V_IDLE;
        endcase
    end

    // Delay line matching the voice pipeline latency, carrying indices to the capture point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly_vld <= '0;
            for (int i = 0; i < VOICE_LAT; i++) dly_slot[i] <= '0;
        end else begin
            dly_vld     <= {dly_vld[VOICE_LAT-2:0], vsel_valid};
            dly_slot[0] <= slot_q;
            for (int i = 1; i < VOICE_LAT; i++) dly_slot[i] <= dly_slot[i-1];
        end
    end

    // Frame-in-progress flag and rejected-start pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            busy    <= accept || (busy && !frame_done);
            overrun <= start && busy && !frame_done;
        end
    end

    sid_filter_seq #(
        .NUM_SIDS (NUM_SIDS),
        .SID_W    (SID_W)
    ) u_filter_seq (
        .clk         (clk),
        .rst         (rst),
        .mark_vld    (mark_vld),
        .mark_sid    (SID_W'(dly_slot[VOICE_LAT-2].sid)),
        .filt_load   (filt_load),
        .filt_sid    (filt_sid),
        .filt_stage  (filt_stage),
        .audio_valid (audio_valid),
        .audio_sid   (audio_sid),
        .frame_done  (frame_done)
    );
endmodule

// File: tb/tb_sid_pipe_sched.sv
// Bench for sid_pipe_sched: NUM_SIDS=2 and NUM_SIDS=4 instances, table of frame scenarios.
// Expected strobes come from the documented timing formulas, queued per accepted start.
// Each DUT strobe pops and compares the next expected event of its kind.
module tb_sid_pipe_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start2 = 1'b0, start4 = 1'b0;
    bit   use4 = 1'b0;

    logic b2, vv2, va2, cv2, fl2, av2, fd2, ov2;
    logic [1:0] vs2, vvo2, cs2, cvo2, fs2, as2;
    logic [2:0] fst2;
    logic b4, vv4, va4, cv4, fl4, av4, fd4, ov4;
    logic [1:0] vs4, vvo4, cs4, cvo4, fs4, as4;
    logic [2:0] fst4;

    typedef struct packed {
        logic busy; logic vsel_valid; logic [1:0] vsel_sid; logic [1:0] vsel_voice;
        logic voice_active; logic cap_valid; logic [1:0] cap_sid; logic [1:0] cap_voice;
        logic filt_load; logic [1:0] filt_sid; logic [2:0] filt_stage;
        logic audio_valid; logic [1:0] audio_sid; logic frame_done; logic overrun;
    } obs_t;
    obs_t obs;

    typedef struct { int kind; int cyc; int a; int b; } ev_t;
    ev_t evq [$];

    typedef struct {
        string name; bit use4; int s0; int s1; int rst_at; int ncyc;
        int exp_frames; int exp_ovr;
    } case_t;
    case_t tbl [5];

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    int last_acc = -1000;
    int nsids = 2;
    int frames, ovrs;

    sid_pipe_sched #(.NUM_SIDS(2), .SID_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(b2),
        .vsel_valid(vv2), .vsel_sid(vs2), .vsel_voice(vvo2), .voice_active(va2),
        .cap_valid(cv2), .cap_sid(cs2), .cap_voice(cvo2),
        .filt_load(fl2), .filt_sid(fs2), .filt_stage(fst2),
        .audio_valid(av2), .audio_sid(as2), .frame_done(fd2), .overrun(ov2)
    );

    sid_pipe_sched #(.NUM_SIDS(4), .SID_W(2)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .busy(b4),
        .vsel_valid(vv4), .vsel_sid(vs4), .vsel_voice(vvo4), .voice_active(va4),
        .cap_valid(cv4), .cap_sid(cs4), .cap_voice(cvo4),
        .filt_load(fl4), .filt_sid(fs4), .filt_stage(fst4),
        .audio_valid(av4), .audio_sid(as4), .frame_done(fd4), .overrun(ov4)
    );

    always #5 clk = ~clk;

    always_comb begin
        if (use4)
            obs = {b4, vv4, vs4, vvo4, va4, cv4, cs4, cvo4, fl4, fs4, fst4, av4, as4, fd4, ov4};
        else
            obs = {b2, vv2, vs2, vvo2, va2, cv2, cs2, cvo2, fl2, fs2, fst2, av2, as2, fd2, ov2};
    end

    function automatic bit exp_busy(input int c);
        return (c >= last_acc + 1) && (c <= last_acc + 6 + 7 * nsids);
    endfunction

    task automatic add(input int k, input int c, input int a, input int b);
        ev_t e;
        e.kind = k; e.cyc = c; e.a = a; e.b = b;
        evq.push_back(e);
    endtask

    // Expected strobes of one frame started at cycle c.
    task automatic push_frame(input int c);
        for (int s = 0; s < nsids; s++) begin
            for (int v = 0; v < 3; v++) begin
                add(0, c + 1 + 3 * s + v, s, v);
                add(1, c + 2 + 3 * s + v, 0, 0);
                add(2, c + 3 + 3 * s + v, s, v);
            end
            add(3, c + 5 + 7 * s, s, 0);
            for (int j = 0; j < 7; j++) add(4, c + 6 + 7 * s + j, j + 1, 0);
            add(5, c + 13 + 7 * s, s, (s == nsids - 1) ? 1 : 0);
        end
    endtask

    task automatic chk(input int k, input string nm, input logic fired, input int a, input int b);
        int idx;
        ev_t e;
        idx = -1;
        for (int i = 0; i < evq.size(); i++) begin
            if (evq[i].kind == k) begin
                idx = i;
                break;
            end
        end
        if (fired) begin
            n_chk++;
            if (idx < 0) begin
                n_fail++;
                $display("FAIL %s: strobe at cycle %0d (%0d,%0d), none expected", nm, cyc, a, b);
            end else begin
                e = evq[idx];
                evq.delete(idx);
                if (e.cyc != cyc || e.a != a || e.b != b) begin
                    n_fail++;
                    $display("FAIL %s: got cycle %0d (%0d,%0d), expected cycle %0d (%0d,%0d)",
                             nm, cyc, a, b, e.cyc, e.a, e.b);
                end
            end
        end else if (idx >= 0 && evq[idx].cyc <= cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: missing strobe, expected cycle %0d (%0d,%0d)", nm, evq[idx].cyc,
                     evq[idx].a, evq[idx].b);
            evq.delete(idx);
        end
    endtask

    task automatic check_zero(input string nm);
        n_chk++;
        if (obs != '0) begin
            n_fail++;
            $display("FAIL %s: outputs %h, expected all zero", nm, obs);
        end
    endtask

    task automatic run_case(input case_t tc);
        bit st;
        use4   = tc.use4;
        nsids  = tc.use4 ? 4 : 2;
        rst    = 1'b1;
        start2 = 1'b0;
        start4 = 1'b0;
        repeat (2) @(negedge clk);
        check_zero({tc.name, " reset state"});
        rst      = 1'b0;
        evq.delete();
        last_acc = -1000;
        frames   = 0;
        ovrs     = 0;
        for (int c = 0; c < tc.ncyc; c++) begin
            cyc = c;
            @(negedge clk);
            chk(0, "vsel", obs.vsel_valid, int'(obs.vsel_sid), int'(obs.vsel_voice));
            chk(1, "voice_active", obs.voice_active, 0, 0);
            chk(2, "cap", obs.cap_valid, int'(obs.cap_sid), int'(obs.cap_voice));
            chk(3, "filt_load", obs.filt_load, int'(obs.filt_sid), 0);
            chk(4, "filt_stage", obs.filt_stage != 3'd0, int'(obs.filt_stage), 0);
            chk(5, "audio", obs.audio_valid | obs.frame_done,
                obs.audio_valid ? int'(obs.audio_sid) : -1, int'(obs.frame_done));
            chk(6, "overrun", obs.overrun, 0, 0);
            n_chk++;
            if (obs.busy != exp_busy(c)) begin
                n_fail++;
                $display("FAIL busy: cycle %0d got %0b expected %0b", c, obs.busy, exp_busy(c));
            end
            frames += int'(obs.frame_done);
            ovrs   += int'(obs.overrun);
            if (c == tc.rst_at) begin
                rst = 1'b1;
                #1;
                check_zero({tc.name, " mid-frame reset"});
                evq.delete();
                last_acc = -1000;
            end else if (c == tc.rst_at + 1) begin
                rst = 1'b0;
            end
            st = (c == tc.s0 || c == tc.s1) && !rst;
            if (st) begin
                if (!exp_busy(c) || c == last_acc + 6 + 7 * nsids) begin
                    push_frame(c);
                    last_acc = c;
                end else begin
                    add(6, c + 1, 0, 0);
                end
            end
            start2 = st && !tc.use4;
            start4 = st && tc.use4;
            @(posedge clk);
        end
        start2 = 1'b0;
        start4 = 1'b0;
        n_chk++;
        if (evq.size() != 0) begin
            n_fail++;
            $display("FAIL %s leftover: %0d expected strobes never seen, expected 0", tc.name, evq.size());
        end
        n_chk++;
        if (frames != tc.exp_frames) begin
            n_fail++;
            $display("FAIL %s frame_done count: got %0d expected %0d", tc.name, frames, tc.exp_frames);
        end
        n_chk++;
        if (ovrs != tc.exp_ovr) begin
            n_fail++;
            $display("FAIL %s overrun count: got %0d expected %0d", tc.name, ovrs, tc.exp_ovr);
        end
    endtask

    initial begin
        tbl[0] = '{name: "single",   use4: 1'b0, s0: 0, s1: -1, rst_at: -1, ncyc: 26, exp_frames: 1, exp_ovr: 0};
        tbl[1] = '{name: "overrun",  use4: 1'b0, s0: 0, s1: 10, rst_at: -1, ncyc: 28, exp_frames: 1, exp_ovr: 1};
        tbl[2] = '{name: "b2b",      use4: 1'b0, s0: 0, s1: 20, rst_at: -1, ncyc: 46, exp_frames: 2, exp_ovr: 0};
        tbl[3] = '{name: "midreset", use4: 1'b0, s0: 0, s1: 12, rst_at: 9,  ncyc: 38, exp_frames: 1, exp_ovr: 0};
        tbl[4] = '{name: "four",     use4: 1'b1, s0: 0, s1: -1, rst_at: -1, ncyc: 40, exp_frames: 1, exp_ovr: 0};
        for (int t = 0; t < 5; t++) run_case(tbl[t]);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
